led_pattern_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 73 +++++++
 rtl/led_step_timer.sv | 49 ++++
 rtl/led_pattern_sequencer.sv | 134 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types, constants and pattern helpers for the LED bar sequencer.
package led_seq_pkg;

    // Animation modes, advanced in order and wrapping after M_LAST.
    typedef enum logic [2:0] {
        M_FWD    = 3'd0,
        M_BWD    = 3'd1,
        M_BOUNCE = 3'd2,
        M_FILL   = 3'd3,
        M_BLINK  = 3'd4
    } mode_t;

    localparam mode_t M_LAST = M_BLINK;

    // Travel direction of the BOUNCE mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int NUM_LEDS = 10;

    // Highest single-LED position and highest FILL level.
    localparam logic [3:0] POS_MAX  = 4'd9;
    localparam logic [3:0] FILL_MAX = 4'd10;

    // Position loaded when a mode is entered.
    localparam logic [3:0] SEED_FWD    = 4'd0;
    localparam logic [3:0] SEED_BWD    = 4'd9;
    localparam logic [3:0] SEED_BOUNCE = 4'd0;
    localparam logic [3:0] SEED_FILL   = 4'd1;
    localparam logic [3:0] SEED_BLINK  = 4'd0;

    // Hexdigit codes understood by the 7-segment modules.
    localparam logic [4:0] HEX_MINUS = 5'd17;
    localparam logic [4:0] HEX_OFF   = 5'd20;

    localparam logic [1:0] SPEED_MAX = 2'd3;

    // LED drive at reset: FWD mode, LED0 lit, active-low.
    localparam logic [NUM_LEDS-1:0] LED_N_RST = 10'b11_1111_1110;

    function automatic mode_t next_mode(input mode_t m);
        if (m == M_LAST) begin
            return M_FWD;
        end
        return mode_t'(m + 3'd1);
    endfunction

    function automatic logic [3:0] seed_pos(input mode_t m);
        case (m)
            M_FWD:    return SEED_FWD;
            M_BWD:    return SEED_BWD;
            M_BOUNCE: return SEED_BOUNCE;
            M_FILL:   return SEED_FILL;
            M_BLINK:  return SEED_BLINK;
            default:  return 4'd0;
        endcase
    endfunction

    // Active-high LED image for a mode at a given position.
    function automatic logic [NUM_LEDS-1:0] led_pattern(input mode_t m, input logic [3:0] pos);
        logic [NUM_LEDS:0] fill;
        fill = (11'd1 << pos) - 11'd1;
        case (m)
            M_FWD, M_BWD, M_BOUNCE: return 10'd1 << pos;
            M_FILL:                 return fill[NUM_LEDS-1:0];
            M_BLINK:                return pos[0] ? 10'h000 : 10'h3FF;
            default:                return 10'h000;
        endcase
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Free-running step counter producing a single-cycle terminal-count pulse.
// A clear dominates both counting and a coincident terminal count.
module led_step_timer
    import led_seq_pkg::*;
#(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic             en,
    input  logic             clr,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == period - CNT_W'(1));

    // Next count and terminal-count pulse.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        cnt_d = cnt_q;
        tc    = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (at_last) begin
                cnt_d = '0;
                tc    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps the 10-LED bar through animation modes at one of four rates and
// drives active-low LEDs plus mode and speed/pause hexdigit codes.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int BASE_DIV = 3125000,
    parameter int CNT_W    = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_p,
    input  logic                speed_p,
    input  logic                pause_p,
    output logic [NUM_LEDS-1:0] led_n,
    output logic [4:0]          hex_mode,
    output logic [4:0]          hex_speed,
    output logic                step
);

    mode_t               mode_q,      mode_d;
    logic [1:0]          speed_q,     speed_d;
    logic                paused_q,    paused_d;
    logic [3:0]          pos_q,       pos_d;
    dir_t                dir_q,       dir_d;
    logic                step_q,      step_d;
    logic [NUM_LEDS-1:0] led_n_q,     led_n_d;
    logic [4:0]          hex_mode_q,  hex_mode_d;
    logic [4:0]          hex_speed_q, hex_speed_d;

    logic [CNT_W-1:0]    period;
    logic                tc;

    // Step period doubles with each speed level.
    assign period = CNT_W'(BASE_DIV) << speed_q;

    // Mode and speed changes restart the count, which also cancels a coincident step.
    led_step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .en     (!paused_q),
        .clr    (mode_p | speed_p),
        .tc     (tc)
    );

    // Button handling and pattern advance; registered outputs follow the next state.
    always_comb begin
        mode_d   = mode_q;
        speed_d  = speed_q;
        paused_d = paused_q ^ pause_p;
        pos_d    = pos_q;
        dir_d    = dir_q;
        step_d   = tc;

        if (speed_p) begin
            speed_d = (speed_q == SPEED_MAX) ? 2'd0 : speed_q + 2'd1;
        end

        if (mode_p) begin
            mode_d = next_mode(mode_q);
            pos_d  = seed_pos(mode_d);
            dir_d  = DIR_UP;
        end else if (tc) begin
            case (mode_q)
                M_FWD: begin
                    pos_d = (pos_q == POS_MAX) ? 4'd0 : pos_q + 4'd1;
                end
                M_BWD: begin
                    pos_d = (pos_q == 4'd0) ? POS_MAX : pos_q - 4'd1;
                end
                M_BOUNCE: begin
                    // Turn around on arrival so each endpoint is shown only once.
                    if (dir_q == DIR_UP) begin
                        pos_d = pos_q + 4'd1;
                        if (pos_q == POS_MAX - 4'd1) begin
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        pos_d = pos_q - 4'd1;
                        if (pos_q == 4'd1) begin
                            dir_d = DIR_UP;
                        end
                    end
                end
                M_FILL: begin
                    pos_d = (pos_q == FILL_MAX) ? 4'd0 : pos_q + 4'd1;
                end
                M_BLINK: begin
                    pos_d = {pos_q[3:1], ~pos_q[0]};
                end
                default: begin
                    pos_d = pos_q;
                end
            endcase
        end

        led_n_d     = ~led_pattern(mode_d, pos_d);
        hex_mode_d  = {2'b00, mode_d};
        hex_speed_d = paused_d ? HEX_MINUS : {3'b000, speed_d};
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= M_FWD;
            speed_q     <= 2'd0;
            paused_q    <= 1'b0;
            pos_q       <= SEED_FWD;
            dir_q       <= DIR_UP;
            step_q      <= 1'b0;
            led_n_q     <= LED_N_RST;
            hex_mode_q  <= 5'd0;
            hex_speed_q <= 5'd0;
        end else begin
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            paused_q    <= paused_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            led_n_q     <= led_n_d;
            hex_mode_q  <= hex_mode_d;
            hex_speed_q <= hex_speed_d;
        end
    end

    assign led_n     = led_n_q;
    assign hex_mode  = hex_mode_q;
    assign hex_speed = hex_speed_q;
    assign step      = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a short step period.
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_p;
    logic       speed_p;
    logic       pause_p;
    logic [9:0] led_n;
    logic [4:0] hex_mode;
    logic [4:0] hex_speed;
    logic       step;

    int checks   = 0;
    int failures = 0;

    int bounce_exp [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    led_pattern_sequencer #(
        .BASE_DIV (4),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_p    (mode_p),
        .speed_p   (speed_p),
        .pause_p   (pause_p),
        .led_n     (led_n),
        .hex_mode  (hex_mode),
        .hex_speed (hex_speed),
        .step      (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Active-low image of a single lit LED.
    function automatic logic [31:0] one_n(input int p);
        return ~(32'd1 << p) & 32'h3FF;
    endfunction

    // Active-low image of LEDs [p-1:0] lit.
    function automatic logic [31:0] fill_n(input int p);
        return ~((32'd1 << p) - 32'd1) & 32'h3FF;
    endfunction

    // Number of clocks until step is seen high; -1 if it never comes.
    task automatic wait_step(output int n);
        bit seen;
        seen = 1'b0;
        n    = -1;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                n    = i;
                seen = 1'b1;
            end
        end
    endtask

    // One-cycle button pulse: 0=mode, 1=speed, 2=pause.
    task automatic pulse(input int which);
        case (which)
            0:       mode_p  = 1'b1;
            1:       speed_p = 1'b1;
            default: pause_p = 1'b1;
        endcase
        @(negedge clk);
        mode_p  = 1'b0;
        speed_p = 1'b0;
        pause_p = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int steps_seen;
        logic [9:0] held;

        rst     = 1'b0;
        mode_p  = 1'b0;
        speed_p = 1'b0;
        pause_p = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", led_n, 32'h3FE);
        check("rst_hex_mode", hex_mode, 0);
        check("rst_hex_speed", hex_speed, 0);
        check("rst_step", step, 0);
        rst = 1'b1;

        // FWD: ten steps of four clocks, wrapping back to LED0.
        for (int k = 1; k <= 10; k++) begin
            wait_step(n);
            check("fwd_gap", n, 4);
            check("fwd_led", led_n, one_n(k % 10));
        end

        // Two mode pulses: BWD seed, then BOUNCE seed.
        pulse(0);
        check("bwd_seed", led_n, 32'h1FF);
        check("bwd_hex", hex_mode, 1);
        pulse(0);
        check("bounce_seed", led_n, 32'h3FE);
        check("bounce_hex", hex_mode, 2);
        for (int k = 0; k < 20; k++) begin
            wait_step(n);
            check("bounce_gap", n, 4);
            check("bounce_led", led_n, one_n(bounce_exp[k]));
        end

        // Speed 3 gives 32-clock spacing; a fourth pulse wraps to speed 0.
        pulse(1);
        pulse(1);
        pulse(1);
        check("speed3_hex", hex_speed, 3);
        check("speed3_led_hold", led_n, one_n(2));
        wait_step(n);
        check("speed3_gap", n, 32);
        check("speed3_led", led_n, one_n(3));
        wait_step(n);
        check("speed3_gap2", n, 32);
        pulse(1);
        check("speed0_hex", hex_speed, 0);
        check("speed0_led_hold", led_n, one_n(4));
        wait_step(n);
        check("speed0_gap", n, 4);
        check("speed0_led", led_n, one_n(5));

        // Pause freezes the pattern; mode changes still load seeds.
        pulse(2);
        check("pause_hex", hex_speed, 17);
        held       = led_n;
        steps_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (step === 1'b1) steps_seen++;
        end
        check("pause_steps", steps_seen, 0);
        check("pause_led", led_n, one_n(5));
        check("pause_led_held", led_n, {22'd0, held});
        pulse(0);
        check("p_fill_seed", led_n, 32'h3FE);
        check("p_fill_hex", hex_mode, 3);
        pulse(0);
        check("p_blink_seed", led_n, 32'h000);
        pulse(0);
        check("p_fwd_seed", led_n, 32'h3FE);
        check("p_fwd_hex", hex_mode, 0);
        pulse(0);
        check("p_bwd_seed", led_n, 32'h1FF);
        check("p_bwd_hex", hex_mode, 1);
        check("p_step", step, 0);
        pulse(2);
        check("unpause_hex", hex_speed, 0);
        wait_step(n);
        check("unpause_gap", n, 4);
        check("unpause_led", led_n, 32'h2FF);

        // FILL: eleven-step cycle through all-on and all-off.
        pulse(0);
        pulse(0);
        check("fill_seed", led_n, 32'h3FE);
        check("fill_hex", hex_mode, 3);
        for (int k = 0; k < 11; k++) begin
            wait_step(n);
            check("fill_gap", n, 4);
            check("fill_led", led_n, fill_n((k + 2) % 11));
        end

        // BLINK: alternates all-on and all-off.
        pulse(0);
        check("blink_seed", led_n, 32'h000);
        check("blink_hex", hex_mode, 4);
        for (int k = 1; k <= 4; k++) begin
            wait_step(n);
            check("blink_led", led_n, (k % 2 == 1) ? 32'h3FF : 32'h000);
        end

        // Mode pulse on the terminal-count edge: seed wins, no step.
        repeat (3) @(negedge clk);
        pulse(0);
        check("mode_tc_step", step, 0);
        check("mode_tc_led", led_n, 32'h3FE);
        check("mode_tc_hex", hex_mode, 0);
        wait_step(n);
        check("mode_tc_gap", n, 4);
        check("mode_tc_next", led_n, 32'h3FD);

        // Speed pulse on the terminal-count edge: no step, pattern held.
        repeat (3) @(negedge clk);
        pulse(1);
        check("speed_tc_step", step, 0);
        check("speed_tc_led", led_n, 32'h3FD);
        check("speed_tc_hex", hex_speed, 1);
        wait_step(n);
        check("speed1_gap", n, 8);
        check("speed1_led", led_n, 32'h3FB);
        pulse(1);
        pulse(1);
        pulse(1);
        check("speed_wrap_hex", hex_speed, 0);

        // Pause on the terminal-count edge still steps, then reset mid-pulse.
        pulse(0);
        check("bwd2_seed", led_n, 32'h1FF);
        repeat (3) @(negedge clk);
        pulse(2);
        check("pause_tc_step", step, 1);
        check("pause_tc_led", led_n, 32'h2FF);
        check("pause_tc_hex", hex_speed, 17);
        #2 rst = 1'b0;
        #1;
        check("arst_led", led_n, 32'h3FE);
        check("arst_step", step, 0);
        check("arst_hex_mode", hex_mode, 0);
        check("arst_hex_speed", hex_speed, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_step(n);
        check("post_rst_gap", n, 4);
        check("post_rst_led", led_n, 32'h3FD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
